// File: rtl/project_mux_pkg.sv
// Shared definitions for the project mux harness: register map, switch states
// and the data word returned when a project window never answers.
package project_mux_pkg;

   localparam logic [7:0]  OFF_ACTIVE   = 8'h00;
   localparam logic [7:0]  OFF_OEB_LO   = 8'h04;
   localparam logic [7:0]  OFF_OEB_HI   = 8'h08;
   localparam logic [7:0]  OFF_STATUS   = 8'h0C;
   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_RELEASE = 2'd2
   } sw_state_e;

   function automatic logic [31:0] status_word(input logic busy, input logic sticky,
                                               input logic [7:0] cur);
      return {16'h0000, cur, 6'b000000, sticky, busy};
   endfunction

endpackage

// File: rtl/project_mux_if.sv
// Wishbone slave bus between the management master and the project mux harness.
interface project_mux_if;

   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );

endinterface

// File: rtl/project_switch_fsm.sv
// Project switch sequencer: drains all pads and holds every project in reset
// for a fixed number of cycles before handing the pads to the new project.
module project_switch_fsm
   import project_mux_pkg::*;
#(
   parameter int NUM_PROJECTS  = 8,
   parameter int SWITCH_CYCLES = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_wr_active,
   input  logic [7:0]              i_wr_value,
   output logic                    o_busy,
   output logic [7:0]              o_current,
   output logic [NUM_PROJECTS-1:0] o_proj_rst_n
);

   localparam int                      CNT_W    = $clog2(SWITCH_CYCLES);
   localparam logic [CNT_W-1:0]        CNT_LOAD = CNT_W'(SWITCH_CYCLES - 1);
   localparam logic [NUM_PROJECTS-1:0] ONE_HOT0 = {{(NUM_PROJECTS-1){1'b0}}, 1'b1};

   sw_state_e               r_state, w_state_nxt;
   logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
   logic [7:0]              r_target, w_target_nxt;
   logic [7:0]              r_current, w_current_nxt;
   logic [NUM_PROJECTS-1:0] r_rst_n, w_rst_n_nxt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= {CNT_W{1'b0}};
         r_target  <= 8'h00;
         r_current <= 8'h00;
         r_rst_n   <= {NUM_PROJECTS{1'b0}};
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_target  <= w_target_nxt;
         r_current <= w_current_nxt;
         r_rst_n   <= w_rst_n_nxt;
      end
   end

   // Any ACTIVE write while switching retargets and restarts the drain.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_target_nxt  = r_target;
      w_current_nxt = r_current;
      case (r_state)
         ST_IDLE: begin
            if (i_wr_active && (i_wr_value != r_current)) begin
               w_state_nxt  = ST_DRAIN;
               w_cnt_nxt    = CNT_LOAD;
               w_target_nxt = i_wr_value;
            end else begin
               w_state_nxt  = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (i_wr_active) begin
               w_cnt_nxt    = CNT_LOAD;
               w_target_nxt = i_wr_value;
            end else if (r_cnt == {CNT_W{1'b0}}) begin
               w_state_nxt   = ST_RELEASE;
               w_current_nxt = r_target;
            end else begin
               w_cnt_nxt     = r_cnt - CNT_W'(1'b1);
            end
         end
         ST_RELEASE: begin
            if (i_wr_active) begin
               w_state_nxt  = ST_DRAIN;
               w_cnt_nxt    = CNT_LOAD;
               w_target_nxt = i_wr_value;
            end else begin
               w_state_nxt  = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      // An out-of-range project shifts out of the vector, leaving all resets held.
      if (w_state_nxt == ST_DRAIN) begin
         w_rst_n_nxt = {NUM_PROJECTS{1'b0}};
      end else begin
         w_rst_n_nxt = ONE_HOT0 << w_current_nxt;
      end
   end

   assign o_busy       = (r_state == ST_DRAIN);
   assign o_current    = r_current;
   assign o_proj_rst_n = r_rst_n;

endmodule

// File: rtl/project_mux_harness.sv
// Pad multiplexer for several user projects with a Wishbone control page and
// one pass-through Wishbone window per project.
module project_mux_harness
   import project_mux_pkg::*;
#(
   parameter int          NUM_PROJECTS  = 8,
   parameter int          IO_PADS       = 38,
   parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
   parameter int          SWITCH_CYCLES = 16,
   parameter int          ACK_TIMEOUT   = 15
) (
   input  logic                            wb_clk_i,
   input  logic                            wb_rst_ni,
   project_mux_if.slave                    wb,
   input  logic [IO_PADS-1:0]              io_in,
   output logic [IO_PADS-1:0]              io_out,
   output logic [IO_PADS-1:0]              io_oeb,
   output logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_in,
   input  logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_out,
   output logic [NUM_PROJECTS-1:0]         proj_rst_no,
   output logic [NUM_PROJECTS-1:0]         proj_stb_o,
   input  logic [NUM_PROJECTS-1:0]         proj_ack_i,
   input  logic [NUM_PROJECTS*32-1:0]      proj_dat_i
);

   localparam logic [23:0]      BASE_PAGE = BASE_ADDR[31:8];
   localparam int               TO_W      = $clog2(ACK_TIMEOUT);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(ACK_TIMEOUT - 1);

   logic                    r_ack;
   logic [31:0]             r_dat;
   logic [7:0]              r_active;
   logic [IO_PADS-1:0]      r_oeb;
   logic                    r_sticky;
   logic [TO_W-1:0]         r_wcnt;

   logic                    w_accept, w_ctrl, w_win_any, w_win_ack, w_wr_active, w_busy;
   logic [23:0]             w_page;
   logic [7:0]              w_off, w_current;
   logic [31:0]             w_rd;
   logic [NUM_PROJECTS-1:0] w_win_oh, w_sel_oh;
   logic [IO_PADS-1:0]      w_out_chain [NUM_PROJECTS+1];
   logic [31:0]             w_dat_chain [NUM_PROJECTS+1];

   assign w_accept    = wb.wbs_cyc_i & wb.wbs_stb_i & ~r_ack;
   // Page 0 is the control page, pages 1..NUM_PROJECTS are the project windows.
   assign w_page      = wb.wbs_adr_i[31:8] - BASE_PAGE;
   assign w_off       = wb.wbs_adr_i[7:0];
   assign w_ctrl      = (w_page == 24'h00_0000);
   assign w_wr_active = w_accept & w_ctrl & wb.wbs_we_i & (w_off == OFF_ACTIVE) & wb.wbs_sel_i[0];

   assign w_out_chain[0] = {IO_PADS{1'b0}};
   assign w_dat_chain[0] = 32'h0000_0000;

   for (genvar k = 0; k < NUM_PROJECTS; k++) begin : g_proj
      assign w_win_oh[k] = (w_page == 24'(k + 1));
      assign w_sel_oh[k] = ~w_busy & (w_current == 8'(k));
      assign proj_io_in[k*IO_PADS +: IO_PADS] = w_sel_oh[k] ? io_in : {IO_PADS{1'b0}};
      assign w_out_chain[k+1] = w_out_chain[k] |
                                (w_sel_oh[k] ? proj_io_out[k*IO_PADS +: IO_PADS] : {IO_PADS{1'b0}});
      assign w_dat_chain[k+1] = w_dat_chain[k] |
                                (w_win_oh[k] ? proj_dat_i[k*32 +: 32] : 32'h0000_0000);
   end

   assign w_win_any  = |w_win_oh;
   assign w_win_ack  = |(w_win_oh & proj_ack_i);
   assign proj_stb_o = w_win_oh & {NUM_PROJECTS{w_accept}};
   assign io_out     = w_out_chain[NUM_PROJECTS];
   assign io_oeb     = w_busy ? {IO_PADS{1'b1}} : r_oeb;
   assign wb.wbs_ack_o = r_ack;
   assign wb.wbs_dat_o = r_dat;

   project_switch_fsm #(
      .NUM_PROJECTS  (NUM_PROJECTS),
      .SWITCH_CYCLES (SWITCH_CYCLES)
   ) u_fsm (
      .i_clk        (wb_clk_i),
      .i_rst_n      (wb_rst_ni),
      .i_wr_active  (w_wr_active),
      .i_wr_value   (wb.wbs_dat_i[7:0]),
      .o_busy       (w_busy),
      .o_current    (w_current),
      .o_proj_rst_n (proj_rst_no)
   );

   // Control page read mux.
   always_comb begin
      w_rd = 32'h0000_0000;
      case (w_off)
         OFF_ACTIVE: w_rd = {24'h00_0000, r_active};
         OFF_OEB_LO: w_rd = r_oeb[31:0];
         OFF_OEB_HI: w_rd = 32'(r_oeb >> 6'd32);
         OFF_STATUS: w_rd = status_word(w_busy, r_sticky, w_current);
         default:    w_rd = 32'h0000_0000;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_ack    <= 1'b0;
         r_dat    <= 32'h0000_0000;
         r_active <= 8'h00;
         r_oeb    <= {IO_PADS{1'b0}};
         r_sticky <= 1'b0;
         r_wcnt   <= {TO_W{1'b0}};
      end else begin
         r_ack <= 1'b0;
         r_dat <= 32'h0000_0000;
         if (w_accept && w_ctrl) begin
            r_ack  <= 1'b1;
            r_dat  <= wb.wbs_we_i ? 32'h0000_0000 : w_rd;
            r_wcnt <= {TO_W{1'b0}};
            if (w_wr_active) begin
               r_active <= wb.wbs_dat_i[7:0];
            end
            if (wb.wbs_we_i && (wb.wbs_sel_i == 4'hF) && (w_off == OFF_OEB_LO)) begin
               r_oeb[31:0] <= wb.wbs_dat_i;
            end
            if (wb.wbs_we_i && (wb.wbs_sel_i == 4'hF) && (w_off == OFF_OEB_HI)) begin
               r_oeb <= {wb.wbs_dat_i[IO_PADS-33:0], r_oeb[31:0]};
            end
            if (wb.wbs_we_i && (w_off == OFF_STATUS)) begin
               r_sticky <= 1'b0;
            end
         end else if (w_accept && w_win_any) begin
            if (w_win_ack) begin
               r_ack  <= 1'b1;
               r_dat  <= w_dat_chain[NUM_PROJECTS];
               r_wcnt <= {TO_W{1'b0}};
            end else if (r_wcnt == TO_LAST) begin
               r_ack    <= 1'b1;
               r_dat    <= TIMEOUT_DATA;
               r_sticky <= 1'b1;
               r_wcnt   <= {TO_W{1'b0}};
            end else begin
               r_wcnt <= r_wcnt + TO_W'(1'b1);
            end
         end else begin
            r_wcnt <= {TO_W{1'b0}};
         end
      end
   end

endmodule

// File: tb/tb_project_mux_harness.sv
// Directed bench for project_mux_harness: register access, project switching,
// window timeout and pad routing with hand-computed expectations.
module tb_project_mux_harness;

   localparam int NP  = 8;
   localparam int IOP = 38;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [IOP-1:0]  io_in;
   logic [IOP-1:0]  io_out, io_oeb;
   logic [NP*IOP-1:0] proj_io_in, proj_io_out;
   logic [NP-1:0]   proj_rst_no, proj_stb_o, proj_ack_i;
   logic [NP*32-1:0] proj_dat_i;

   int tests = 0;
   int fails = 0;
   logic [31:0] rd;
   int lat;
   int drain_len;

   project_mux_if wb ();

   project_mux_harness dut (
      .wb_clk_i    (clk),
      .wb_rst_ni   (rst_n),
      .wb          (wb.slave),
      .io_in       (io_in),
      .io_out      (io_out),
      .io_oeb      (io_oeb),
      .proj_io_in  (proj_io_in),
      .proj_io_out (proj_io_out),
      .proj_rst_no (proj_rst_no),
      .proj_stb_o  (proj_stb_o),
      .proj_ack_i  (proj_ack_i),
      .proj_dat_i  (proj_dat_i)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [IOP-1:0] pat(input int k);
      return {6'(k + 1), 32'hA5A5_0000 | 32'(k)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wb_xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] wdat, output logic [31:0] rdat, output int nlat);
      @(posedge clk); #1;
      wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
      wb.wbs_sel_i = sel;  wb.wbs_adr_i = adr;  wb.wbs_dat_i = wdat;
      nlat = -1; rdat = 32'h0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (wb.wbs_ack_o) begin
            nlat = i; rdat = wb.wbs_dat_o;
            break;
         end
      end
      wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
   endtask

   task automatic measure_drain(output int n);
      n = 0;
      while ((io_oeb === {IOP{1'b1}}) && (n < 100)) begin
         n++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
      wb.wbs_sel_i = 4'h0; wb.wbs_adr_i = 32'h0; wb.wbs_dat_i = 32'h0;
      io_in = 38'h2A_1234_5678;
      proj_ack_i = 8'h00;
      for (int k = 0; k < NP; k++) begin
         proj_io_out[k*IOP +: IOP] = pat(k);
         proj_dat_i[k*32 +: 32]    = 32'hC0DE_0000 | 32'(k);
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_proj_rst_no", proj_rst_no, 8'h00);
      chk("rst_io_oeb", io_oeb, 38'h0);
      chk("rst_ack", wb.wbs_ack_o, 1'b0);
      chk("rst_dat", wb.wbs_dat_o, 32'h0);
      chk("rst_proj_stb", proj_stb_o, 8'h00);
      rst_n = 1'b1;
      #1;
      chk("rst_no_before_edge", proj_rst_no, 8'h00);
      @(posedge clk); #1;
      chk("rst_no_first_edge", proj_rst_no, 8'h01);

      wb_xfer(1'b0, 4'hF, 32'h3000_0000, 32'h0, rd, lat);
      chk("active_rd_lat", lat, 1);
      chk("active_rd_dat", rd, 32'h0);
      chk("dat_zero_after_ack", wb.wbs_dat_o, 32'h0);
      wb_xfer(1'b0, 4'hF, 32'h3000_000C, 32'h0, rd, lat);
      chk("status_rst", rd, 32'h0);
      chk("idle_io_out_p0", io_out, pat(0));
      chk("idle_io_in_p0", proj_io_in[0 +: IOP], io_in);
      chk("idle_io_in_p1", proj_io_in[IOP +: IOP], 38'h0);

      // Switch to project 3
      wb_xfer(1'b1, 4'h1, 32'h3000_0000, 32'h3, rd, lat);
      chk("wr3_lat", lat, 1);
      chk("drain_oeb", io_oeb, {IOP{1'b1}});
      chk("drain_io_out", io_out, 38'h0);
      chk("drain_rst_no", proj_rst_no, 8'h00);
      chk("drain_io_in", proj_io_in, {(NP*IOP){1'b0}});
      measure_drain(drain_len);
      chk("drain_len_3", drain_len, 16);
      chk("p3_rst_no", proj_rst_no, 8'h08);
      chk("p3_io_out", io_out, pat(3));
      chk("p3_io_in", proj_io_in[3*IOP +: IOP], io_in);
      wb_xfer(1'b0, 4'hF, 32'h3000_000C, 32'h0, rd, lat);
      chk("status_p3", rd, 32'h0000_0300);

      // Retarget mid-drain: 2 then 5
      wb_xfer(1'b1, 4'hF, 32'h3000_0000, 32'h2, rd, lat);
      wb_xfer(1'b0, 4'hF, 32'h3000_000C, 32'h0, rd, lat);
      chk("status_busy", rd, 32'h0000_0301);
      repeat (7) @(posedge clk);
      #1;
      wb_xfer(1'b1, 4'hF, 32'h3000_0000, 32'h5, rd, lat);
      measure_drain(drain_len);
      chk("drain_len_restart", drain_len, 16);
      chk("p5_rst_no", proj_rst_no, 8'h20);
      wb_xfer(1'b0, 4'hF, 32'h3000_000C, 32'h0, rd, lat);
      chk("status_p5", rd, 32'h0000_0500);

      // Project windows
      proj_ack_i = 8'h04;
      wb_xfer(1'b0, 4'hF, 32'h3000_0300, 32'h0, rd, lat);
      chk("win2_lat", lat, 1);
      chk("win2_dat", rd, 32'hC0DE_0002);
      @(posedge clk); #1;
      wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
      wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = 32'h3000_0500;
      #1;
      chk("win4_stb", proj_stb_o, 8'h10);
      lat = -1; rd = 32'h0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (wb.wbs_ack_o) begin
            lat = i; rd = wb.wbs_dat_o;
            break;
         end
      end
      wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
      chk("win4_to_lat", lat, 15);
      chk("win4_to_dat", rd, 32'hDEAD_BEEF);
      wb_xfer(1'b0, 4'hF, 32'h3000_000C, 32'h0, rd, lat);
      chk("status_sticky", rd, 32'h0000_0502);
      wb_xfer(1'b1, 4'hF, 32'h3000_000C, 32'h0, rd, lat);
      wb_xfer(1'b0, 4'hF, 32'h3000_000C, 32'h0, rd, lat);
      chk("status_cleared", rd, 32'h0000_0500);
      wb_xfer(1'b0, 4'hF, 32'h3000_0900, 32'h0, rd, lat);
      chk("beyond_no_ack", lat, -1);
      wb_xfer(1'b0, 4'hF, 32'h3000_0040, 32'h0, rd, lat);
      chk("unmapped_lat", lat, 1);
      chk("unmapped_dat", rd, 32'h0);

      // OEB byte-lane rules
      wb_xfer(1'b1, 4'h3, 32'h3000_0004, 32'hFFFF_FFFF, rd, lat);
      chk("oeb_partial_lat", lat, 1);
      chk("oeb_partial_io", io_oeb, 38'h0);
      wb_xfer(1'b1, 4'hF, 32'h3000_0004, 32'h0000_FF00, rd, lat);
      chk("oeb_lo_io", io_oeb, 38'h00_0000_FF00);
      wb_xfer(1'b1, 4'hF, 32'h3000_0008, 32'hFFFF_FFFF, rd, lat);
      chk("oeb_hi_io", io_oeb, 38'h3F_0000_FF00);
      wb_xfer(1'b0, 4'hF, 32'h3000_0008, 32'h0, rd, lat);
      chk("oeb_hi_rd", rd, 32'h0000_003F);
      wb_xfer(1'b0, 4'hF, 32'h3000_0004, 32'h0, rd, lat);
      chk("oeb_lo_rd", rd, 32'h0000_FF00);

      // ACTIVE writes that must not switch
      wb_xfer(1'b1, 4'hE, 32'h3000_0000, 32'h7, rd, lat);
      chk("active_nosel_oeb", io_oeb, 38'h3F_0000_FF00);
      wb_xfer(1'b0, 4'hF, 32'h3000_0000, 32'h0, rd, lat);
      chk("active_nosel_rd", rd, 32'h5);
      wb_xfer(1'b1, 4'hF, 32'h3000_0000, 32'h5, rd, lat);
      @(posedge clk); #1;
      chk("active_same_oeb", io_oeb, 38'h3F_0000_FF00);
      chk("active_same_rst", proj_rst_no, 8'h20);

      // Out-of-range project
      wb_xfer(1'b1, 4'hF, 32'h3000_0000, 32'h9, rd, lat);
      measure_drain(drain_len);
      chk("drain_len_9", drain_len, 16);
      chk("p9_io_out", io_out, 38'h0);
      chk("p9_rst_no", proj_rst_no, 8'h00);
      chk("p9_oeb", io_oeb, 38'h3F_0000_FF00);
      chk("p9_io_in", proj_io_in, {(NP*IOP){1'b0}});
      wb_xfer(1'b0, 4'hF, 32'h3000_000C, 32'h0, rd, lat);
      chk("status_p9", rd, 32'h0000_0900);

      // Reset in the middle of a drain
      wb_xfer(1'b1, 4'hF, 32'h3000_0000, 32'h1, rd, lat);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_rst_no", proj_rst_no, 8'h00);
      chk("abort_oeb", io_oeb, 38'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_rst_no_p0", proj_rst_no, 8'h01);
      wb_xfer(1'b0, 4'hF, 32'h3000_000C, 32'h0, rd, lat);
      chk("abort_status", rd, 32'h0);
      wb_xfer(1'b0, 4'hF, 32'h3000_0000, 32'h0, rd, lat);
      chk("abort_active", rd, 32'h0);
      repeat (20) @(posedge clk);
      #1;
      chk("abort_no_switch", proj_rst_no, 8'h01);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
